// File: rtl/framebuf_db_if.sv
// rtl/framebuf_db_if.sv - renderer write port and video scan port of the double-buffered frame store
interface framebuf_db_if;
   logic [7:0] wr_h;
   logic [7:0] wr_v;
   logic [2:0] wr_r;
   logic [2:0] wr_g;
   logic [1:0] wr_b;
   logic       wr_done;
   logic       wr_frame;
   logic       vs;
   logic       ce_pix;
   logic [7:0] hcnt;
   logic [7:0] vcnt;
   logic       hblank;
   logic       vblank;
   logic [2:0] r;
   logic [2:0] g;
   logic [1:0] b;
   logic       swapped;

   modport master (
      output wr_h, wr_v, wr_r, wr_g, wr_b, wr_done, wr_frame,
      output ce_pix, hcnt, vcnt, hblank, vblank,
      input  vs, r, g, b, swapped
   );

   modport slave (
      input  wr_h, wr_v, wr_r, wr_g, wr_b, wr_done, wr_frame,
      input  ce_pix, hcnt, vcnt, hblank, vblank,
      output vs, r, g, b, swapped
   );
endinterface

// File: rtl/framebuf_db.sv
// rtl/framebuf_db.sv - double-buffered 256x256 RGB332 frame store, bank swap on vblank rising edge
module framebuf_db #(
   parameter logic [7:0] BLANK_COLOR = 8'h00
) (
   input  logic          clk,
   input  logic          reset,
   framebuf_db_if.slave  fb
);
   logic [7:0]  bank0 [0:65535];
   logic [7:0]  bank1 [0:65535];
   logic [7:0]  rdata0;
   logic [7:0]  rdata1;
   logic        disp_bank;
   logic        swap_pending;
   logic        done_d;
   logic        frame_d;
   logic        vb_d;
   logic        rst_d;
   logic        rd_bank;
   logic        blank_q;
   logic        vs_q;
   logic        swapped_q;
   logic [7:0]  pix;
   logic        write;
   logic        frame_rise;
   logic        vb_rise;
   logic        do_swap;
   logic [15:0] wr_addr;
   logic [15:0] rd_addr;
   logic [7:0]  wr_data;

   assign wr_addr = {fb.wr_v, fb.wr_h};
   assign rd_addr = {fb.vcnt, fb.hcnt};
   assign wr_data = {fb.wr_r, fb.wr_g, fb.wr_b};

   // rst_d blocks a wr_done level still high at release from looking like a fresh edge
   always_comb begin
      write      = fb.wr_done & ~done_d & ~rst_d & ~reset;
      frame_rise = fb.wr_frame & ~frame_d;
      vb_rise    = fb.vblank & ~vb_d;
      do_swap    = vb_rise & (swap_pending | frame_rise);
   end

   always_ff @(posedge clk) begin
      if (write && disp_bank)
         bank0[wr_addr] <= wr_data;
      if (fb.ce_pix)
         rdata0 <= bank0[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (write && !disp_bank)
         bank1[wr_addr] <= wr_data;
      if (fb.ce_pix)
         rdata1 <= bank1[rd_addr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         disp_bank    <= 1'b0;
         swap_pending <= 1'b0;
         done_d       <= 1'b0;
         frame_d      <= 1'b0;
         vb_d         <= 1'b0;
         rst_d        <= 1'b1;
         swapped_q    <= 1'b0;
         vs_q         <= 1'b0;
         rd_bank      <= 1'b0;
         blank_q      <= 1'b1;
         pix          <= BLANK_COLOR;
      end else begin
         rst_d     <= 1'b0;
         done_d    <= fb.wr_done;
         frame_d   <= fb.wr_frame;
         vb_d      <= fb.vblank;
         vs_q      <= fb.vblank;
         swapped_q <= do_swap;
         if (do_swap) begin
            disp_bank    <= ~disp_bank;
            swap_pending <= 1'b0;
         end else if (frame_rise) begin
            swap_pending <= 1'b1;
         end
         // rd_bank remembers which bank the captured address was read from,
         // so a swap between two pixel strobes cannot tear the pixel
         if (fb.ce_pix) begin
            rd_bank <= disp_bank;
            blank_q <= fb.hblank | fb.vblank;
            pix     <= blank_q ? BLANK_COLOR : (rd_bank ? rdata1 : rdata0);
         end
      end
   end

   assign fb.vs      = vs_q;
   assign fb.swapped = swapped_q;
   assign fb.r       = pix[7:5];
   assign fb.g       = pix[4:2];
   assign fb.b       = pix[1:0];
endmodule

// File: doc/framebuf_db.md
FRAMEBUF_DB -- requirements
Module: framebuf_db

Interface
REQ-001 SHALL have parameter: BLANK_COLOR, 8'h00, {r,g,b} value driven while hblank or vblank is active.
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: wr_h  input  8  renderer pixel column.
REQ-005 SHALL have port: wr_v  input  8  renderer pixel row.
REQ-006 SHALL have ports: wr_r  input  3, wr_g  input  3, wr_b  input  2  renderer pixel colour.
REQ-007 SHALL have port: wr_done  input  1  renderer pixel-valid level; a write occurs on its rising edge.
REQ-008 SHALL have port: wr_frame  input  1  renderer end-of-frame level/pulse; rising edge requests a buffer swap.
REQ-009 SHALL have port: vs  output  1  renderer hold-off; equals vblank, registered.
REQ-010 SHALL have port: ce_pix  input  1  pixel clock enable; asserted at most every 2nd clk.
REQ-011 SHALL have ports: hcnt  input  8, vcnt  input  8  current scan position.
REQ-012 SHALL have ports: hblank  input  1, vblank  input  1  video blanking.
REQ-013 SHALL have ports: r  output  3, g  output  3, b  output  2  video pixel out.
REQ-014 SHALL have port: swapped  output  1  one-clk pulse when the display bank toggles.

Function
REQ-015 SHALL contain two 65536x8 banks, addressed {v,h}, data {r,g,b}; each bank has one write port and one registered read port.
REQ-016 SHALL keep disp_bank; write bank is always ~disp_bank; the display bank is never written.
REQ-017 SHALL register wr_done into done_d every clk; write = wr_done & ~done_d.
REQ-018 On write SHALL store {wr_r,wr_g,wr_b} at {wr_v,wr_h} in the write bank, sampled the same cycle as the rising edge.
REQ-019 A held-high wr_done SHALL produce exactly one write; back-to-back rising edges 2 clk apart SHALL both be written.
REQ-020 SHALL register wr_frame into frame_d; on wr_frame & ~frame_d set swap_pending.
REQ-021 SHALL register vblank into vb_d; at vblank & ~vb_d, if swap_pending (or it is being set that cycle): toggle disp_bank, clear swap_pending, pulse swapped for one clk.
REQ-022 A frame request arriving during active vblank SHALL wait for the next vblank rising edge.
REQ-023 A second frame request while pending SHALL be absorbed (single swap).
REQ-024 A write coincident with a swap SHALL go to the pre-swap write bank.
REQ-025 Read address SHALL be {vcnt,hcnt} captured on ce_pix cycles; memory data available next clk.
REQ-026 On each ce_pix SHALL update r,g,b with data for the position captured at the previous ce_pix (latency exactly one pixel), or BLANK_COLOR if hblank|vblank sampled at that previous ce_pix.
REQ-027 Outputs SHALL hold between ce_pix pulses.
REQ-028 Coordinates SHALL wrap modulo 256 with no bounds checks.

Reset
REQ-029 Reset SHALL set disp_bank=0, swap_pending=0, done_d=0, frame_d=0, vb_d=0, swapped=0, vs=0, and {r,g,b}=BLANK_COLOR.
REQ-030 A wr_done rising edge in the reset cycle SHALL be dropped; wr_done still high on release SHALL NOT write (done_d loaded 0 but write gated until one clk after release).
REQ-031 Bank contents SHALL NOT be cleared by reset.

Verification
REQ-032 Reset, wr_h=5, wr_v=7, rgb=8'hA5, wr_done 0->1 held 4 clk; request a swap; scan (5,7) -> r,g,b=A5 one pixel later; bank 1 word 0x0705 written once.
REQ-033 wr_frame pulse mid-active; vblank rises 100 clk later -> swapped pulses exactly at vblank rising edge; disp_bank=1.
REQ-034 wr_frame rises during vblank -> no swap until next vblank rising edge.
REQ-035 Write to (0,0) with value 8'h3C while display scans (0,0) of the other bank -> displayed value unchanged until swap.
REQ-036 hblank=1 with ce_pix -> next pixel out = BLANK_COLOR; vs follows vblank by one clk.
REQ-037 Assert reset mid-frame with swap_pending=1 -> no swap at next vblank; disp_bank=0.
